// File: rtl/ofm_lane_collector.sv
// Collects one result per PE lane into a 16-lane holding register.
// The downstream controller then drains the register in four groups of four lanes.
module ofm_lane_collector #(
    parameter int DW  = 8,
    parameter int TCW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [15:0]       pe_valid,
    input  logic [16*DW-1:0]  pe_data,
    output logic [15:0]       pe_ready,
    input  logic [1:0]        control_mux,
    input  logic              wr_en_next,
    output logic [15:0]       OFM_data_out_valid,
    output logic [4*DW-1:0]   ofm_group_data,
    output logic              drain_done,
    output logic [TCW-1:0]    tile_count,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lane_valid_q, lane_valid_d;
    logic [DW-1:0]   lane_data_q [16];
    logic [DW-1:0]   lane_data_d [16];
    logic            drain_done_q, drain_done_d;
    logic [TCW-1:0]  tile_count_q, tile_count_d;
    logic [1:0]      err_q, err_d;

    logic [15:0]     accept;
    logic            tile_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            lane_valid_q <= '0;
            drain_done_q <= 1'b0;
            tile_count_q <= '0;
            err_q        <= '0;
            for (int i = 0; i < 16; i++) begin
                lane_data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lane_valid_q <= lane_valid_d;
            drain_done_q <= drain_done_d;
            tile_count_q <= tile_count_d;
            err_q        <= err_d;
            for (int i = 0; i < 16; i++) begin
                lane_data_q[i] <= lane_data_d[i];
            end
        end
    end

    // Release fires from FULL as well, so a drain that starts on group 3 is not lost.
    always_comb begin
        state_d      = state_q;
        lane_valid_d = lane_valid_q;
        drain_done_d = 1'b0;
        tile_count_d = tile_count_q;
        err_d        = err_q;
        for (int i = 0; i < 16; i++) begin
            lane_data_d[i] = lane_data_q[i];
        end

        accept       = pe_valid & pe_ready;
        tile_release = wr_en_next && (control_mux == 2'd3) &&
                       ((state_q == FULL) || (state_q == DRAIN));

        if (|(pe_valid & ~pe_ready)) begin
            err_d[0] = 1'b1;
        end
        if (wr_en_next && (state_q == COLLECT)) begin
            err_d[1] = 1'b1;
        end

        case (state_q)
            COLLECT: begin
                for (int i = 0; i < 16; i++) begin
                    if (accept[i]) begin
                        lane_data_d[i] = pe_data[i*DW +: DW];
                    end
                end
                lane_valid_d = lane_valid_q | accept;
                if (&lane_valid_d) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (wr_en_next) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if (tile_release) begin
            lane_valid_d = '0;
            drain_done_d = 1'b1;
            tile_count_d = tile_count_q + 1'b1;
            state_d      = COLLECT;
        end

        if (clr) begin
            state_d      = COLLECT;
            lane_valid_d = '0;
            drain_done_d = 1'b0;
            tile_count_d = '0;
            err_d        = '0;
            for (int i = 0; i < 16; i++) begin
                lane_data_d[i] = '0;
            end
        end
    end

    always_comb begin
        pe_ready = (state_q == COLLECT) ? ~lane_valid_q : 16'h0000;
        ofm_group_data = '0;
        for (int k = 0; k < 4; k++) begin
            ofm_group_data[k*DW +: DW] = lane_data_q[{control_mux, k[1:0]}];
        end
    end

    assign OFM_data_out_valid = lane_valid_q;
    assign drain_done         = drain_done_q;
    assign tile_count         = tile_count_q;
    assign err                = err_q;

endmodule

// File: tb/tb_ofm_lane_collector.sv
// Directed self-checking bench for ofm_lane_collector (DW=8, TCW=16).
module tb_ofm_lane_collector;

    localparam int DW  = 8;
    localparam int TCW = 16;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic [15:0]       pe_valid;
    logic [16*DW-1:0]  pe_data;
    logic [15:0]       pe_ready;
    logic [1:0]        control_mux;
    logic              wr_en_next;
    logic [15:0]       OFM_data_out_valid;
    logic [4*DW-1:0]   ofm_group_data;
    logic              drain_done;
    logic [TCW-1:0]    tile_count;
    logic [1:0]        err;

    int checks;
    int errors;

    ofm_lane_collector #(.DW(DW), .TCW(TCW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clr                (clr),
        .pe_valid           (pe_valid),
        .pe_data            (pe_data),
        .pe_ready           (pe_ready),
        .control_mux        (control_mux),
        .wr_en_next         (wr_en_next),
        .OFM_data_out_valid (OFM_data_out_valid),
        .ofm_group_data     (ofm_group_data),
        .drain_done         (drain_done),
        .tile_count         (tile_count),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            pe_data[i*DW +: DW] = base + 8'(i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (OFM_data_out_valid !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %h expected %h", OFM_data_out_valid, 16'h0000);
        end
        checks++;
        if (pe_ready !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %h expected %h", pe_ready, 16'hFFFF);
        end
        checks++;
        if (drain_done !== 1'b0 || tile_count !== 16'd0 || err !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_status: got done=%b tiles=%0d err=%b expected 0/0/00",
                     drain_done, tile_count, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        set_data(8'h01);
        pe_valid = 16'hFFFF;
        tick();
        pe_valid = 16'h0000;
        checks++;
        if (OFM_data_out_valid !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL fill_valid: got %h expected %h", OFM_data_out_valid, 16'hFFFF);
        end
        checks++;
        if (pe_ready !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL fill_ready: got %h expected %h", pe_ready, 16'h0000);
        end
        checks++;
        if (err !== 2'b00) begin
            errors++;
            $display("[TB] FAIL fill_err: got %b expected %b", err, 2'b00);
        end
    endtask

    task automatic test_drain(input logic [7:0] base, input logic [15:0] tiles_exp);
        logic [31:0] grp_exp;
        for (int m = 0; m < 4; m++) begin
            wr_en_next  = 1'b1;
            control_mux = 2'(m);
            #1;
            for (int k = 0; k < 4; k++) begin
                grp_exp[k*8 +: 8] = base + 8'(4*m + k);
            end
            checks++;
            if (ofm_group_data !== grp_exp) begin
                errors++;
                $display("[TB] FAIL drain_group%0d: got %h expected %h", m, ofm_group_data, grp_exp);
            end
            if (m < 3) begin
                checks++;
                if (OFM_data_out_valid !== 16'hFFFF || drain_done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL drain_hold%0d: got valid=%h done=%b expected FFFF/0",
                             m, OFM_data_out_valid, drain_done);
                end
            end
            tick();
        end
        wr_en_next  = 1'b0;
        control_mux = 2'd0;
        #1;
        checks++;
        if (OFM_data_out_valid !== 16'h0000 || drain_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_release: got valid=%h done=%b expected 0000/1",
                     OFM_data_out_valid, drain_done);
        end
        checks++;
        if (tile_count !== tiles_exp) begin
            errors++;
            $display("[TB] FAIL drain_tiles: got %0d expected %0d", tile_count, tiles_exp);
        end
        checks++;
        if (pe_ready !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL drain_reopen: got %h expected %h", pe_ready, 16'hFFFF);
        end
        tick();
        checks++;
        if (drain_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_pulse: got %b expected %b", drain_done, 1'b0);
        end
    endtask

    task automatic test_staggered();
        set_data(8'h10);
        pe_valid = 16'h00FF;
        tick();
        pe_data[7:0] = 8'hAA;
        pe_valid     = 16'h0001;
        tick();
        pe_valid = 16'h0000;
        checks++;
        if (err !== 2'b01) begin
            errors++;
            $display("[TB] FAIL stagger_overflow: got %b expected %b", err, 2'b01);
        end
        tick();
        set_data(8'h10);
        pe_valid = 16'hFF00;
        checks++;
        if (OFM_data_out_valid !== 16'h00FF) begin
            errors++;
            $display("[TB] FAIL stagger_partial: got %h expected %h", OFM_data_out_valid, 16'h00FF);
        end
        tick();
        pe_valid = 16'h0000;
        checks++;
        if (OFM_data_out_valid !== 16'hFFFF || pe_ready !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL stagger_full: got valid=%h ready=%h expected FFFF/0000",
                     OFM_data_out_valid, pe_ready);
        end
        control_mux = 2'd0;
        #1;
        checks++;
        if (ofm_group_data !== 32'h13121110) begin
            errors++;
            $display("[TB] FAIL stagger_lane0: got %h expected %h", ofm_group_data, 32'h13121110);
        end
        test_drain(8'h10, 16'd2);
    endtask

    task automatic test_protocol();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (err !== 2'b00 || tile_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL proto_clr: got err=%b tiles=%0d expected 00/0", err, tile_count);
        end
        set_data(8'h20);
        pe_valid = 16'h001F;
        tick();
        pe_valid   = 16'h0000;
        wr_en_next = 1'b1;
        control_mux = 2'd3;
        tick();
        wr_en_next  = 1'b0;
        control_mux = 2'd0;
        checks++;
        if (err !== 2'b10) begin
            errors++;
            $display("[TB] FAIL proto_err: got %b expected %b", err, 2'b10);
        end
        checks++;
        if (OFM_data_out_valid !== 16'h001F || drain_done !== 1'b0 || pe_ready !== 16'hFFE0) begin
            errors++;
            $display("[TB] FAIL proto_hold: got valid=%h done=%b ready=%h expected 001F/0/FFE0",
                     OFM_data_out_valid, drain_done, pe_ready);
        end
    endtask

    task automatic test_reset_mid_drain();
        pe_valid = 16'hFFE0;
        tick();
        pe_valid = 16'h0000;
        for (int m = 0; m < 2; m++) begin
            wr_en_next  = 1'b1;
            control_mux = 2'(m);
            tick();
        end
        control_mux = 2'd2;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (OFM_data_out_valid !== 16'h0000 || ofm_group_data !== 32'h0 ||
            tile_count !== 16'd0 || err !== 2'b00 || drain_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got valid=%h grp=%h tiles=%0d err=%b done=%b expected all 0",
                     OFM_data_out_valid, ofm_group_data, tile_count, err, drain_done);
        end
        wr_en_next  = 1'b0;
        control_mux = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        set_data(8'h01);
        pe_valid = 16'hFFFF;
        tick();
        pe_valid = 16'h0000;
        test_drain(8'h01, 16'd1);
    endtask

    task automatic test_clr();
        pe_valid = 16'h0003;
        tick();
        pe_valid   = 16'h0000;
        wr_en_next = 1'b1;
        tick();
        clr        = 1'b1;
        pe_valid   = 16'hFFFF;
        wr_en_next = 1'b1;
        tick();
        clr        = 1'b0;
        pe_valid   = 16'h0000;
        wr_en_next = 1'b0;
        checks++;
        if (OFM_data_out_valid !== 16'h0000 || err !== 2'b00 || tile_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clr_state: got valid=%h err=%b tiles=%0d expected 0000/00/0",
                     OFM_data_out_valid, err, tile_count);
        end
        checks++;
        if (pe_ready !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL clr_ready: got %h expected %h", pe_ready, 16'hFFFF);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        clr         = 1'b0;
        pe_valid    = 16'h0000;
        pe_data     = '0;
        control_mux = 2'd0;
        wr_en_next  = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_drain(8'h01, 16'd1);
        test_staggered();
        test_protocol();
        test_reset_mid_drain();
        test_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
